// File: rtl/signal_edge_logger.sv
// signal_edge_logger
//   Watches a single synchronous signal and logs every transition as
//   {new_level, timestamp} into a small FIFO that a host drains through a
//   valid/ready port.
//
// Ports
//   clk        : clock, all logic on posedge
//   rst_n      : asynchronous active-low reset
//   en         : log detected edges when high
//   sig_in     : monitored signal (already synchronous to clk)
//   evt_valid  : FIFO non-empty, head event presented on evt_data
//   evt_ready  : host accepts the head when evt_valid && evt_ready
//   evt_data   : {level, timestamp} of the head event
//   evt_count  : number of stored events (0..DEPTH)
//   overflow   : sticky, an edge was dropped because the FIFO was full
//   clr_ovf    : single-cycle pulse clearing overflow
module signal_edge_logger #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     sig_in,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [TS_W:0]            evt_data,
  output logic [$clog2(DEPTH):0]   evt_count,
  output logic                     overflow,
  input  logic                     clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic            sig_q;
  logic [TS_W-1:0] ts_q;
  logic [AW-1:0]   wr_q, rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic [TS_W:0]   head_q, head_d;
  logic [TS_W:0]   mem_q [DEPTH];

  logic            want, full, push, pop;
  logic [TS_W:0]   push_data;

  always_comb begin
    want      = (sig_in != sig_q) && en;
    full      = (cnt_q == CW'(DEPTH));
    pop       = (cnt_q != '0) && evt_ready;
    push      = want && (!full || pop);
    push_data = {sig_in, ts_q};
    rd_d      = rd_q + AW'(pop);

    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);

    // A drop sets the flag even when clr_ovf arrives in the same cycle.
    ovf_d = ovf_q;
    if (clr_ovf)                 ovf_d = 1'b0;
    if (want && full && !pop)    ovf_d = 1'b1;

    // The head register tracks mem[rd_d]; when the slot becoming head is the
    // one being written this cycle (empty FIFO, or a single entry popped
    // while pushing), the incoming event is forwarded instead.
    if (push && (wr_q == rd_d)) head_d = push_data;
    else                        head_d = mem_q[rd_d];
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q  <= 1'b0;
      ts_q   <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      head_q <= '0;
    end else begin
      sig_q  <= sig_in;
      ts_q   <= ts_q + TS_W'(1);
      if (push) wr_q <= wr_q + AW'(1);
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      head_q <= head_d;
    end
  end

  assign evt_valid = (cnt_q != '0);
  assign evt_data  = head_q;
  assign evt_count = cnt_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_signal_edge_logger.sv
`timescale 1ns/1ps
module tb_signal_edge_logger;

  localparam int TS_W  = 16;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b1;
  logic          sig_in = 1'b0;
  logic          evt_valid;
  logic          evt_ready = 1'b0;
  logic [TS_W:0] evt_data;
  logic [3:0]    evt_count;
  logic          overflow;
  logic          clr_ovf = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [TS_W:0]   exp_q[$];
  logic [TS_W:0]   popped[$];
  logic            exp_ovf;
  logic            sig_prev;
  logic            lvl;
  logic [TS_W-1:0] tb_ts;

  signal_edge_logger #(.TS_W(TS_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
    .evt_count(evt_count), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  // Reference timestamp: the value the logger stamps at the next posedge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_ts <= '0;
    else        tb_ts <= tb_ts + 16'd1;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model the edge the upcoming posedge will see and update the scoreboard.
  task automatic model_edge(input logic s, input logic e, input logic clr, input logic pop,
                            input int size_before);
    logic want;
    want = (s != sig_prev) && e;
    if (clr) exp_ovf = 1'b0;
    if (want) begin
      if (size_before < DEPTH || pop) exp_q.push_back({s, tb_ts});
      else exp_ovf = 1'b1;
    end
    sig_prev = s;
  endtask

  // One cycle: at the negedge check outputs against the scoreboard, then
  // drive the inputs for the following posedge.
  task automatic drive(input logic s, input logic r, input logic e, input logic clr);
    int  size_before;
    logic pop;
    @(negedge clk);
    chk("count", 32'(evt_count), 32'(exp_q.size()));
    chk("valid", 32'(evt_valid), 32'(exp_q.size() != 0));
    chk("ovf", 32'(overflow), 32'(exp_ovf));
    if (exp_q.size() != 0) chk("head", 32'(evt_data), 32'(exp_q[0]));
    size_before = exp_q.size();
    pop = r && (size_before != 0);
    if (pop) popped.push_back(exp_q.pop_front());
    model_edge(s, e, clr, pop, size_before);
    sig_in = s; evt_ready = r; en = e; clr_ovf = clr;
  endtask

  task automatic do_reset(input logic s);
    rst_n = 1'b0; sig_in = s; en = 1'b1; evt_ready = 1'b0; clr_ovf = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_count", 32'(evt_count), 32'd0);
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_data", 32'(evt_data), 32'd0);
    exp_q.delete(); popped.delete();
    exp_ovf = 1'b0; sig_prev = 1'b0;
    rst_n = 1'b1;
    // The first posedge after release sees sig_in against sig_q = 0.
    model_edge(s, 1'b1, 1'b0, 1'b0, 0);
    lvl = s;
  endtask

  initial begin
    // Reset / first sample
    do_reset(1'b1);
    @(negedge clk);
    chk("first_data", 32'(evt_data), 32'h1_0000);
    chk("first_count", 32'(evt_count), 32'd1);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0);

    // Toggling signal: rise at ts=3, period 10
    do_reset(1'b0);
    for (int t = 1; t <= 40; t++) begin
      lvl = (t >= 3) && ((((t - 3) / 5) % 2) == 0);
      drive(lvl, 1'b1, 1'b1, 1'b0);
    end
    drive(lvl, 1'b1, 1'b1, 1'b0);
    chk("tog_ev0", 32'(popped[0]), 32'h1_0003);
    chk("tog_ev1", 32'(popped[1]), 32'h0_0008);
    chk("tog_ev2", 32'(popped[2]), 32'h1_000D);
    chk("tog_ovf", 32'(overflow), 32'd0);

    // Fill and overflow
    do_reset(1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      lvl = ~lvl;
      drive(lvl, 1'b0, 1'b1, 1'b0);
    end
    drive(lvl, 1'b0, 1'b1, 1'b0);
    chk("fill_count", 32'(evt_count), 32'd8);
    chk("fill_ovf", 32'(overflow), 32'd1);
    // Drop and clear in the same cycle: the flag stays set.
    lvl = ~lvl;
    drive(lvl, 1'b0, 1'b1, 1'b1);
    drive(lvl, 1'b0, 1'b1, 1'b0);
    chk("setwins_ovf", 32'(overflow), 32'd1);
    popped.delete();
    for (int i = 0; i < 8; i++) drive(lvl, 1'b1, 1'b1, 1'b0);
    drive(lvl, 1'b0, 1'b1, 1'b1);
    drive(lvl, 1'b0, 1'b1, 1'b0);
    chk("drain_n", 32'(popped.size()), 32'd8);
    chk("clr_ovf", 32'(overflow), 32'd0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 8; i++) begin
      lvl = ~lvl;
      drive(lvl, 1'b0, 1'b1, 1'b0);
    end
    lvl = ~lvl;
    drive(lvl, 1'b1, 1'b1, 1'b0);
    drive(lvl, 1'b0, 1'b1, 1'b0);
    chk("pp_count", 32'(evt_count), 32'd8);
    chk("pp_ovf", 32'(overflow), 32'd0);
    popped.delete();
    for (int i = 0; i < 8; i++) drive(lvl, 1'b1, 1'b1, 1'b0);
    drive(lvl, 1'b0, 1'b1, 1'b0);
    chk("pp_last_lvl", 32'(popped[7][TS_W]), 32'(lvl));
    chk("pp_empty", 32'(evt_count), 32'd0);

    // Enable gating and timestamp wrap
    for (int i = 0; i < 3; i++) begin
      lvl = ~lvl;
      drive(lvl, 1'b1, 1'b0, 1'b0);
    end
    drive(lvl, 1'b1, 1'b1, 1'b0);
    drive(lvl, 1'b1, 1'b1, 1'b0);
    chk("gate_count", 32'(evt_count), 32'd0);
    for (int i = 0; i < 70000 && tb_ts != 16'hFFFE; i++) drive(lvl, 1'b0, 1'b1, 1'b0);
    popped.delete();
    lvl = ~lvl;
    drive(lvl, 1'b0, 1'b1, 1'b0);
    lvl = ~lvl;
    drive(lvl, 1'b0, 1'b1, 1'b0);
    drive(lvl, 1'b1, 1'b1, 1'b0);
    drive(lvl, 1'b1, 1'b1, 1'b0);
    drive(lvl, 1'b0, 1'b1, 1'b0);
    chk("wrap_n", 32'(popped.size()), 32'd2);
    chk("wrap_ev0", 32'(popped[0]), {15'd0, ~lvl, 16'hFFFF});
    chk("wrap_ev1", 32'(popped[1]), {15'd0, lvl, 16'h0000});
    chk("wrap_ovf", 32'(overflow), 32'd0);

    // Reset mid-drain
    for (int i = 0; i < 4; i++) begin
      lvl = ~lvl;
      drive(lvl, 1'b0, 1'b1, 1'b0);
    end
    drive(lvl, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(evt_valid), 32'd0);
    chk("arst_count", 32'(evt_count), 32'd0);
    do_reset(1'b1);
    @(negedge clk);
    chk("arst_ts0", 32'(evt_data), 32'h1_0000);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/signal_edge_logger.md
# signal_edge_logger

Captures every transition of a single-bit monitored signal and records it as a timestamped event. Events go into an internal FIFO, and a host/test harness drains it through a valid/ready read port. The block is the observing end of toggling-signal stimulus: it records what a driver such as a clock-synchronous inverter produces, so benches can check edge timing without `$display`. It sits beside the DUT in the same clock domain.

## Interface
- `TS_W`, 16: width of the free-running timestamp counter.
- `DEPTH`, 8: FIFO entries. Must be a power of two, ≥2.
- `clk` input 1: single clock; all logic on posedge.
- `rst_n` input 1: asynchronous, active-low reset.
- `en` input 1: when high, detected edges are logged; when low, edges are ignored.
- `sig_in` input 1: monitored signal, already synchronous to `clk`.
- `evt_valid` output 1: FIFO non-empty; head event on `evt_data`.
- `evt_ready` input 1: host pops the head when `evt_valid && evt_ready`.
- `evt_data` output TS_W+1: bit TS_W = new level of `sig_in` (1 = posedge, 0 = negedge); bits TS_W-1:0 = timestamp.
- `evt_count` output $clog2(DEPTH)+1: number of stored events.
- `overflow` output 1: sticky flag; an edge was dropped because the FIFO was full.
- `clr_ovf` input 1: one-cycle pulse that clears `overflow`.

## Operation
- `sig_q` register: `sig_q <= sig_in` every cycle, regardless of `en`. An edge is defined as `sig_in != sig_q` at a posedge `clk`.
- `ts` counter: increments by 1 every cycle and wraps modulo 2^TS_W. It is not gated by `en`.
- Logged event at an edge: `{sig_in, ts}`, where `ts` is the value before that cycle's increment.
- Push rule: push when an edge occurs, `en` is high, and the FIFO is not full, or the FIFO is full but a pop happens in the same cycle.
  - Full with no pop: the event is dropped and `overflow` is set.
  - Empty with push and pop in the same cycle: not possible, because `evt_valid` is low, so the pop is ignored.
- Pop rule: `evt_valid && evt_ready` advances the read pointer.
  - Pop on an empty FIFO is ignored; `evt_ready` is don't-care when `evt_valid` is low.
- `evt_count`:
  - +1 on a push-only cycle.
  - −1 on a pop-only cycle.
  - Unchanged on a simultaneous push and pop.
  - Range 0..DEPTH.
- Pointers: $clog2(DEPTH) bits each, wrapping naturally. Full/empty are derived from `evt_count`.
- `overflow` priority: a set in the same cycle as `clr_ovf` wins, so the flag stays 1.
- `evt_data` is the registered FIFO head. It is stable while `evt_valid && !evt_ready`, and is don't-care when `evt_valid` is low.

## Timing
- Reset values while `rst_n` is low:
  - `sig_q` = 0, `ts` = 0, pointers = 0.
  - `evt_count` = 0, `evt_valid` = 0, `overflow` = 0.
  - `evt_data` = 0.
- Reset mid-operation: all stored events are discarded immediately (asynchronously).
- First cycle after release: if `sig_in` = 1, a posedge is detected, because `sig_q` was 0.
- Latency: an edge sampled at posedge N appears on `evt_valid`/`evt_data` after posedge N, i.e. visible in cycle N+1. This is one cycle when the FIFO was empty.
- Throughput: one push and one pop per cycle.
  - A signal toggling every cycle with `evt_ready` held high never overflows.
- Timestamp wrap: the event logged at `ts` = 2^TS_W−1 is followed by one stamped 0. No flag is raised.
- Back-to-back edges on consecutive cycles produce consecutive entries with timestamps differing by 1.

## Test plan
- **Reset/first sample:** TS_W=16. Hold `rst_n`=0 with `sig_in`=1, then release. Expect a posedge event at `ts`=0, `evt_data`=17'h1_0000, `evt_count`=1 one cycle later.
- **Toggling clock-derived signal:** `sig_in` inverts every 5 cycles starting with a rise at `ts`=3, `evt_ready`=1. Expect events `{1,3}`, `{0,8}`, `{1,13}`, … with `overflow`=0.
- **Fill/overflow:** DEPTH=8, `evt_ready`=0, 10 edges. Expect:
  - `evt_count`=8 and `overflow`=1.
  - Draining yields exactly the first 8 events in order.
  - A `clr_ovf` pulse drops `overflow` to 0.
- **Full with simultaneous push/pop:** FIFO full, edge and pop in the same cycle. Expect `evt_count` to stay 8, `overflow` to stay 0, and the new event to appear last on drain.
- **Enable gating/wrap:** `en`=0 during 3 edges → no events. Set `en`=1 and make an edge at `ts`=16'hFFFF, then another edge next cycle. Expect events `{x,16'hFFFF}` then `{~x,16'h0000}`.
- **Reset mid-drain:** 4 events stored, assert `rst_n`=0 asynchronously mid-cycle. Expect `evt_valid`=0 and `evt_count`=0 immediately, and `ts` restarting at 0.
